mcu_scheduler: RTL
==================

// Module: mcu_scheduler
// PURPOSE
//  Sequences the fdct_quant datapath across one frame. Per 8-line stripe landed in camera_buf,
//  issues one fdct_go per MCU and tracks MCU column/row; stalls while the entropy-encoder FIFO is
//  almost full. Holds credits for up to STRIPES stripes.
//  Sits between camera (stripe pulses) and fdct_quant, in the clk domain.
// PARAMETERS
//  W_PW      11  picture width bits (pic_width_i is W_PW+1 bits)
//  W_PH      11  picture height bits
//  MB_SHIFT  4   log2 MCU width in pixels (3 = YUV444, 4 = YUV422); MCU height fixed at 8
//  STRIPES   2   camera_buf stripe capacity (>=1)
// PORTS
//  clk                 in   1        core clock
//  rstn                in   1        asynchronous active-low reset
//  pic_width_i         in   W_PW+1   picture width, pixels; sampled on frame_start_i
//  pic_height_i        in   W_PH+1   picture height, lines; sampled on frame_start_i
//  frame_start_i       in   1        1-cycle pulse: new frame (vsync edge)
//  stripe_ready_i      in   1        1-cycle pulse: one 8-line stripe written to camera_buf
//  ee_afull_i          in   1        ee FIFO almost full, ee_clk domain; 2-flop synced inside
//  fdct_ready_i        in   1        1-cycle pulse: fdct_quant done with current MCU
//  fdct_go_o           out  1        1-cycle pulse: start MCU at mb_col_o/mb_row_o
//  mb_col_o            out  W_PW+1   current MCU column
//  mb_row_o            out  W_PH+1   current MCU row
//  last_mb_in_row_o    out  1        mb_col_o == mbs_w-1
//  last_mb_in_pic_o    out  1        last_mb_in_row_o && mb_row_o == mbs_h-1
//  credits_o           out  clog2(STRIPES+1)  stripes pending
//  frame_done_o        out  1        1-cycle pulse: fdct_ready_i on last MCU of picture
//  err_overrun_o       out  1        1-cycle pulse: stripe arrived with credits == STRIPES
//  stall_cycles_o      out  16       stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, mbs_w = mbs_h = 0, sync flops 0.
//  mbs_w = pic_width_i>>MB_SHIFT, mbs_h = pic_height_i>>3. Both latched on frame_start_i.
//  FSM:
//   IDLE  -> READY on frame_start_i.
//   READY -> GO when credits!=0 && !afull_sync && mbs_w!=0 && mbs_h!=0.
//   GO    -> BUSY. fdct_go_o=1 for exactly this cycle; go is 2 cycles after condition first true.
//   BUSY  -> on fdct_ready_i: READY normally, IDLE if last_mb_in_pic_o.
//  Position (on fdct_ready_i):
//   - col max: col<=0; row<=row+1, or 0 on last row.
//   - otherwise: col<=col+1.
//   Outputs stay stable from GO until fdct_ready_i.
//  Credits:
//   - +1 on stripe_ready_i; -1 on fdct_ready_i at last_mb_in_row_o.
//   - inc and dec in the same cycle: unchanged.
//   - inc at STRIPES with no dec: saturate, err_overrun_o pulses next cycle.
//   - dec at 0 cannot occur; assert in simulation.
//  frame_start_i (any state, incl. mid-MCU):
//   - next state READY; col/row/credits <= 0; new dims latched.
//   - stripe_ready_i in the same cycle still counts: credits <= 1.
//   - an in-flight fdct_ready_i is ignored.
//  fdct_ready_i outside BUSY is ignored.
//  ee_afull_i affects only READY->GO; a GO already issued is never withdrawn.
//  frame_done_o registered: asserts the cycle after the final fdct_ready_i.
// CONFIGURATION
//  MCU_SCHED_STATS_EN defined:
//   - stall_cycles_o +1 each cycle in READY with credits!=0 && afull_sync.
//   - saturates at 16'hFFFF; cleared on frame_start_i and reset.
//  Not defined: stall_cycles_o tied to 0; no counter logic.
// TESTING
//  mbs_w=4 (width 64, MB_SHIFT 4), mbs_h=2; start, 2 stripe pulses, fdct_ready_i 5 cyc after each go
//   -> 8 gos, (col,row) 0..3/0 then 0..3/1, credits 2->1->0, one frame_done_o.
//  afull held 100 cyc with credits=1 in READY -> no go; go 2 cyc after release;
//   stall_cycles_o=100 with STATS_EN, 0 without.
//  STRIPES=2, 3 stripe pulses before any MCU done -> credits=2, err_overrun_o one pulse.
//  stripe_ready_i coincident with row-completing fdct_ready_i at credits=1 -> credits stays 1, next go issued.
//  frame_start_i while BUSY at (2,1) -> col=row=0, READY, late fdct_ready_i ignored, no frame_done_o.
//  pic_width_i=8 with MB_SHIFT 4 (mbs_w=0), stripes supplied -> no fdct_go_o ever.

Source files
------------

// File: rtl/mcu_scheduler.sv
// Purpose : sequences fdct_quant over a frame, one fdct_go_o per MCU, credit per camera_buf stripe.
// Latency : fdct_go_o two cycles after issue condition (credit, !afull_sync, valid dims) first holds.
// Backpr. : holds in READY while ee_afull_i (2-flop synced) is high or no stripe credit is pending.
//
// Ports:
//   clk, rstn                 core clock, async active-low reset
//   pic_width_i/pic_height_i  picture size in pixels/lines, latched on frame_start_i
//   frame_start_i             new frame pulse; restarts from any state
//   stripe_ready_i            one 8-line stripe landed in camera_buf (+1 credit)
//   ee_afull_i                entropy-encoder FIFO almost full (ee_clk domain)
//   fdct_ready_i              fdct_quant finished the current MCU
//   fdct_go_o, mb_col_o, mb_row_o, last_mb_in_row_o, last_mb_in_pic_o  MCU issue + position
//   credits_o                 stripes pending; frame_done_o, err_overrun_o status pulses
//   stall_cycles_o            afull stall counter, present only with MCU_SCHED_STATS_EN defined
module mcu_scheduler #(
  parameter int W_PW     = 11,
  parameter int W_PH     = 11,
  parameter int MB_SHIFT = 4,
  parameter int STRIPES  = 2,
  localparam int W_CR    = $clog2(STRIPES + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [W_PW:0]   pic_width_i,
  input  logic [W_PH:0]   pic_height_i,
  input  logic            frame_start_i,
  input  logic            stripe_ready_i,
  input  logic            ee_afull_i,
  input  logic            fdct_ready_i,
  output logic            fdct_go_o,
  output logic [W_PW:0]   mb_col_o,
  output logic [W_PH:0]   mb_row_o,
  output logic            last_mb_in_row_o,
  output logic            last_mb_in_pic_o,
  output logic [W_CR-1:0] credits_o,
  output logic            frame_done_o,
  output logic            err_overrun_o,
  output logic [15:0]     stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, READY, GO, BUSY} state_t;

  state_t        state_q, state_d;
  logic [W_PW:0] mbs_w_q;
  logic [W_PH:0] mbs_h_q;
  logic          afull_s1, afull_sync;
  logic          rdy_acc, cred_inc, cred_dec, issue_ok;

  // ee_afull_i comes from ee_clk; a single-bit level is safe through two flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      afull_s1   <= 1'b0;
      afull_sync <= 1'b0;
    end else begin
      afull_s1   <= ee_afull_i;
      afull_sync <= afull_s1;
    end
  end

  // With zero dims the wrapped (mbs-1) is all ones, so col/row 0 never flags as last.
  assign last_mb_in_row_o = (mb_col_o == mbs_w_q - 1'b1);
  assign last_mb_in_pic_o = last_mb_in_row_o && (mb_row_o == mbs_h_q - 1'b1);

  // A frame restart wins over a completion arriving in the same cycle.
  assign rdy_acc  = (state_q == BUSY) && fdct_ready_i && !frame_start_i;
  assign cred_inc = stripe_ready_i;
  assign cred_dec = rdy_acc && last_mb_in_row_o;
  assign issue_ok = (credits_o != '0) && !afull_sync && (mbs_w_q != '0) && (mbs_h_q != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      READY:   if (issue_ok) state_d = GO;
      GO:      state_d = BUSY;
      BUSY:    if (rdy_acc) state_d = last_mb_in_pic_o ? IDLE : READY;
      default: state_d = IDLE;
    endcase
    if (frame_start_i) state_d = READY;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mbs_w_q       <= '0;
      mbs_h_q       <= '0;
      mb_col_o      <= '0;
      mb_row_o      <= '0;
      credits_o     <= '0;
      fdct_go_o     <= 1'b0;
      frame_done_o  <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      // Registered from GO so the pulse lands as the FSM enters BUSY.
      fdct_go_o     <= (state_q == GO) && !frame_start_i;
      frame_done_o  <= rdy_acc && last_mb_in_pic_o;
      err_overrun_o <= 1'b0;
      if (frame_start_i) begin
        mbs_w_q   <= pic_width_i >> MB_SHIFT;
        mbs_h_q   <= pic_height_i >> 3;
        mb_col_o  <= '0;
        mb_row_o  <= '0;
        credits_o <= cred_inc ? W_CR'(1) : '0;
      end else begin
        if (rdy_acc) begin
          if (last_mb_in_row_o) begin
            mb_col_o <= '0;
            mb_row_o <= last_mb_in_pic_o ? '0 : mb_row_o + 1'b1;
          end else begin
            mb_col_o <= mb_col_o + 1'b1;
          end
        end
        if (cred_inc && !cred_dec) begin
          if (credits_o == W_CR'(STRIPES)) err_overrun_o <= 1'b1;
          else                             credits_o     <= credits_o + W_CR'(1);
        end else if (cred_dec && !cred_inc) begin
          credits_o <= credits_o - W_CR'(1);
        end
      end
    end
  end

  // Every issued MCU consumed a credit check, so a row can never finish with none pending.
  a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rstn)
                                     !(cred_dec && !cred_inc && !frame_start_i && credits_o == '0));

`ifdef MCU_SCHED_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  stall_q <= '0;
    else if (frame_start_i)     stall_q <= '0;
    else if ((state_q == READY) && (credits_o != '0) && afull_sync && (stall_q != 16'hFFFF))
                                stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 16'd0;
`endif

endmodule
